// File: rtl/yoshi_pkg.sv
// Shared screen/sprite constants and the vertical-motion state encoding,
// used by the jump controller, the platform-contact detector and the renderer.
package yoshi_pkg;

  localparam int unsigned MAX_X = 640;
  localparam int unsigned MAX_Y = 480;
  localparam int unsigned T_W   = 16;
  localparam int unsigned T_H   = 16;

  // Ground row: sprite sits two tiles plus a 16-pixel border above the bottom.
  localparam int unsigned Y_FLOOR_ROW = MAX_Y - 2 * T_H - 16;

  typedef enum logic [1:0] {
    STAND   = 2'd0,
    JUMP_UP = 2'd1,
    FALL    = 2'd2
  } yoshi_state_e;

endpackage

// File: rtl/jump_step_timer.sv
// Step-period generator: holds the current period and a down-counting timer,
// and pulses step_o on the cycle the timer reaches 1 while running.
module jump_step_timer #(
  parameter int unsigned TW    = 20,
  parameter int unsigned INC   = 6000,
  parameter int unsigned DEC   = 6000,
  parameter int unsigned T_MIN = 250000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          add_i,
  input  logic          sub_i,
  output logic          step_o,
  output logic [TW-1:0] add_val_o
);

  localparam logic [TW:0]   INC_W     = (TW+1)'(INC);
  localparam logic [TW:0]   SUB_LIMIT = (TW+1)'(DEC + T_MIN);
  localparam logic [TW-1:0] DEC_V     = TW'(DEC);
  localparam logic [TW-1:0] MIN_V     = TW'(T_MIN);

  logic [TW-1:0] period_q, period_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW:0]   sum;
  logic [TW-1:0] sub_val;

  assign sum       = {1'b0, period_q} + INC_W;
  assign add_val_o = sum[TW] ? '1 : sum[TW-1:0];
  // Subtract only when the result stays at or above the floor; avoids wrap.
  assign sub_val   = ({1'b0, period_q} >= SUB_LIMIT) ? (period_q - DEC_V) : MIN_V;
  assign step_o    = run_i && (timer_q == TW'(1));

  always_comb begin
    period_d = period_q;
    timer_d  = timer_q;
    if (clear_i) begin
      period_d = '0;
      timer_d  = '0;
    end else if (load_i) begin
      period_d = load_val_i;
      timer_d  = load_val_i;
    end else if (add_i) begin
      period_d = add_val_o;
      timer_d  = add_val_o;
    end else if (sub_i) begin
      period_d = sub_val;
      timer_d  = sub_val;
    end else if (run_i && timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      timer_q  <= '0;
    end else begin
      period_q <= period_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: rtl/yoshi_jump.sv
// Vertical-motion controller: owns the sprite y row and the stand/jump/fall FSM.
// Optional YOSHI_VAR_JUMP_EN: releasing the button during the rise cuts the jump short.
module yoshi_jump
  import yoshi_pkg::*;
#(
  parameter int unsigned JUMP_T_START = 250000,
  parameter int unsigned JUMP_T_INC   = 6000,
  parameter int unsigned JUMP_T_MAX   = 1000000,
  parameter int unsigned FALL_T_START = 1000000,
  parameter int unsigned FALL_T_DEC   = 6000,
  parameter int unsigned FALL_T_MIN   = 250000,
  parameter int unsigned Y_TOP        = 0,
  parameter int unsigned Y_FLOOR      = Y_FLOOR_ROW,
  parameter int unsigned TW           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_jump,
  input  logic       grounded,
  output logic [9:0] y_y,
  output logic       jumping_up,
  output logic       jumping_down
);

  localparam logic [9:0]    Y_TOP_V   = 10'(Y_TOP);
  localparam logic [9:0]    Y_FLOOR_V = 10'(Y_FLOOR);
  localparam logic [TW-1:0] JSTART_V  = TW'(JUMP_T_START);
  localparam logic [TW-1:0] JMAX_V    = TW'(JUMP_T_MAX);
  localparam logic [TW-1:0] FSTART_V  = TW'(FALL_T_START);

  yoshi_state_e  state_q, state_d;
  logic [9:0]    y_q, y_d;
  logic          btn_prev_q;
  logic          btn_edge;
  logic          early_rel;
  logic          step;
  logic [TW-1:0] add_val;
  logic          t_run, t_clr, t_load, t_add, t_sub;
  logic [TW-1:0] t_val;

`ifdef YOSHI_VAR_JUMP_EN
  assign early_rel = !btn_jump;
`else
  assign early_rel = 1'b0;
`endif

  assign btn_edge = btn_jump & ~btn_prev_q;

  jump_step_timer #(
    .TW   (TW),
    .INC  (JUMP_T_INC),
    .DEC  (FALL_T_DEC),
    .T_MIN(FALL_T_MIN)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (t_run),
    .clear_i   (t_clr),
    .load_i    (t_load),
    .load_val_i(t_val),
    .add_i     (t_add),
    .sub_i     (t_sub),
    .step_o    (step),
    .add_val_o (add_val)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    t_run   = 1'b0;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_add   = 1'b0;
    t_sub   = 1'b0;
    t_val   = '0;
    case (state_q)
      STAND: begin
        // Losing ground beats a simultaneous button edge.
        if (!grounded) begin
          state_d = FALL;
          t_load  = 1'b1;
          t_val   = FSTART_V;
        end else if (btn_edge) begin
          state_d = JUMP_UP;
          t_load  = 1'b1;
          t_val   = JSTART_V;
        end
      end
      JUMP_UP: begin
        t_run = 1'b1;
        if (early_rel) begin
          state_d = FALL;
          t_load  = 1'b1;
          t_val   = FSTART_V;
        end else if (step) begin
          if (y_q == Y_TOP_V) begin
            state_d = FALL;
            t_load  = 1'b1;
            t_val   = FSTART_V;
          end else begin
            y_d = y_q - 10'd1;
            if (add_val >= JMAX_V) begin
              state_d = FALL;
              t_load  = 1'b1;
              t_val   = FSTART_V;
            end else begin
              t_add = 1'b1;
            end
          end
        end
      end
      FALL: begin
        t_run = 1'b1;
        if (grounded) begin
          state_d = STAND;
          t_clr   = 1'b1;
        end else if (step) begin
          t_sub = 1'b1;
          if (y_q != Y_FLOOR_V) y_d = y_q + 10'd1;
          if (y_d == Y_FLOOR_V) begin
            state_d = STAND;
            t_clr   = 1'b1;
          end
        end
      end
      default: state_d = STAND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STAND;
      y_q        <= Y_FLOOR_V;
      btn_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      btn_prev_q <= btn_jump;
    end
  end

  assign y_y          = y_q;
  assign jumping_up   = (state_q == JUMP_UP);
  assign jumping_down = (state_q == FALL);

endmodule

// File: tb/tb_yoshi_jump.sv
// Directed bench for yoshi_jump with a registered platform-contact model and a
// cycle-stamped expectation queue.
module tb_yoshi_jump;

  logic       clk;
  logic       reset;
  logic       btn_jump;
  logic       grounded;
  logic [9:0] y_y;
  logic       jumping_up;
  logic       jumping_down;

  logic plat_en;
  logic force_air;
  logic gq;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  typedef struct {
    string       tag;
    int unsigned at;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];

  yoshi_jump #(
    .JUMP_T_START(4),
    .JUMP_T_INC  (2),
    .JUMP_T_MAX  (12),
    .FALL_T_START(12),
    .FALL_T_DEC  (2),
    .FALL_T_MIN  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_jump    (btn_jump),
    .grounded    (grounded),
    .y_y         (y_y),
    .jumping_up  (jumping_up),
    .jumping_down(jumping_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Detector model: floor at 432, optional platform at 430, never while rising.
  always @(posedge clk) begin
    if (reset) gq <= 1'b1;
    else       gq <= !jumping_up && (y_y == 10'd432 || (plat_en && y_y == 10'd430));
  end
  assign grounded = force_air ? 1'b0 : gq;

  task automatic push(input string tag, input int unsigned dt, input int y,
                      input logic up, input logic dn);
    exp_t e;
    e.tag = tag;
    e.at  = cyc + dt;
    e.exp = {10'(y), up, dn};
    sb.push_back(e);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    exp_t e;
    logic [11:0] obs;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      while (sb.size() != 0 && sb[0].at <= cyc) begin
        e   = sb.pop_front();
        obs = {y_y, jumping_up, jumping_down};
        checks++;
        assert (obs === e.exp && e.at == cyc) else begin
          fails++;
          $error("FAIL %s cyc=%0d: got y=%0d up=%0b dn=%0b, want y=%0d up=%0b dn=%0b at cyc %0d",
                 e.tag, cyc, obs[11:2], obs[1], obs[0], e.exp[11:2], e.exp[1], e.exp[0], e.at);
        end
      end
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      fails++;
      $error("FAIL %s timeout: got nothing by cyc %0d, want y=%0d up=%0b dn=%0b",
             e.tag, cyc, e.exp[11:2], e.exp[1], e.exp[0]);
    end
  endtask

  task automatic launch();
    btn_jump = 1'b0;
    @(negedge clk);
    btn_jump = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    btn_jump  = 1'b1;
    plat_en   = 1'b0;
    force_air = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, button held through reset
    push("rst_state", 1, 432, 1'b0, 1'b0);
    drain(4);
    reset = 1'b0;
    push("no_jump_held1", 1, 432, 1'b0, 1'b0);
    push("no_jump_held5", 5, 432, 1'b0, 1'b0);
    drain(10);

    // Full jump and fall back to floor
    launch();
    push("launch",     1,  432, 1'b1, 1'b0);
    push("pre_step1",  4,  432, 1'b1, 1'b0);
    push("step431",    5,  431, 1'b1, 1'b0);
    push("step430",    11, 430, 1'b1, 1'b0);
    push("step429",    19, 429, 1'b1, 1'b0);
    push("pre_apex",   28, 429, 1'b1, 1'b0);
    push("apex428",    29, 428, 1'b0, 1'b1);
    push("fall429",    41, 429, 1'b0, 1'b1);
    push("fall430",    51, 430, 1'b0, 1'b1);
    push("fall431",    59, 431, 1'b0, 1'b1);
    push("pre_land",   64, 431, 1'b0, 1'b1);
    push("land432",    65, 432, 1'b0, 1'b0);
    push("stand_hold", 70, 432, 1'b0, 1'b0);
    drain(100);

    // Landing on a platform at row 430
    plat_en = 1'b1;
    repeat (2) @(negedge clk);
    launch();
    push("plat_launch",  1,  432, 1'b1, 1'b0);
    push("plat_rise430", 11, 430, 1'b1, 1'b0);
    push("plat_apex",    29, 428, 1'b0, 1'b1);
    push("plat_reach",   51, 430, 1'b0, 1'b1);
    push("plat_detect",  52, 430, 1'b0, 1'b1);
    push("plat_stand",   53, 430, 1'b0, 1'b0);
    push("plat_hold",    62, 430, 1'b0, 1'b0);
    drain(100);

    // Walk off the platform
    plat_en = 1'b0;
    push("walkoff_fall", 2,  430, 1'b0, 1'b1);
    push("walkoff_pre",  13, 430, 1'b0, 1'b1);
    push("walkoff_431",  14, 431, 1'b0, 1'b1);
    push("walkoff_land", 24, 432, 1'b0, 1'b0);
    drain(40);
    repeat (2) @(negedge clk);

    // Fall condition wins over a simultaneous button edge
    btn_jump = 1'b0;
    @(negedge clk);
    force_air = 1'b1;
    btn_jump  = 1'b1;
    push("fall_wins", 1, 432, 1'b0, 1'b1);
    drain(4);
    force_air = 1'b0;
    push("fall_wins_regnd", 1, 432, 1'b0, 1'b0);
    push("fall_wins_hold",  4, 432, 1'b0, 1'b0);
    drain(8);

    // Reset mid-rise
    launch();
    push("midrise429", 19, 429, 1'b1, 1'b0);
    drain(30);
    reset = 1'b1;
    push("midrise_rst", 1, 432, 1'b0, 1'b0);
    drain(4);
    reset = 1'b0;
    push("post_rst_stand", 3, 432, 1'b0, 1'b0);
    drain(6);

    // Early release after the first step
    launch();
    push("rel_step431", 5, 431, 1'b1, 1'b0);
    drain(10);
    btn_jump = 1'b0;
`ifdef YOSHI_VAR_JUMP_EN
    push("short_fall",   1,  431, 1'b0, 1'b1);
    push("short_pre",    12, 431, 1'b0, 1'b1);
    push("short_land",   13, 432, 1'b0, 1'b0);
    drain(30);
`else
    push("rel_ignored",  1,  431, 1'b1, 1'b0);
    push("rel_apex428",  24, 428, 1'b0, 1'b1);
    push("rel_land",     60, 432, 1'b0, 1'b0);
    drain(80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
